amm_master_pipe: RTL and testbench
==================================

// Module: amm_master_pipe
// PURPOSE
//   Synthesisable, parametrised Avalon-MM master. Successor to the behavioural AMM bus driver.
//   Turns a valid/ready command stream into Avalon-MM read/write transfers and honours waitrequest.
//   Supports pipelined reads: up to RSP_DEPTH reads in flight, returned in order through a response FIFO.
//   Sits between a test sequencer or CPU-side bridge and any Avalon-MM slave, e.g. generated regmaps.
// PARAMETERS
//   ADDR_W     16         Avalon address width (byte address, passed through unchanged)
//   DATA_W     32         data width; multiple of 8
//   STRB_W     DATA_W/8   byteenable width
//   RSP_DEPTH  4          max reads in flight = response FIFO depth; power of 2, >=2
// PORTS
//   clk              in   1        clock; all logic on rising edge
//   reset            in   1        synchronous, active-high reset
//   cmd_valid        in   1        command present
//   cmd_ready        out  1        command accepted when cmd_valid & cmd_ready
//   cmd_we           in   1        1 = write, 0 = read
//   cmd_addr         in   ADDR_W   transfer address
//   cmd_wdata        in   DATA_W   write data (ignored for reads)
//   cmd_strb         in   STRB_W   byte enables (writes); reads always drive all-ones
//   rsp_valid        out  1        read data available
//   rsp_ready        in   1        read data consumed when rsp_valid & rsp_ready
//   rsp_rdata        out  DATA_W   read data, in command order
//   amm_address      out  ADDR_W   Avalon address
//   amm_read         out  1        Avalon read
//   amm_write        out  1        Avalon write
//   amm_writedata    out  DATA_W   Avalon writedata
//   amm_byteenable   out  STRB_W   Avalon byteenable
//   amm_waitrequest  in   1        Avalon waitrequest
//   amm_readdata     in   DATA_W   Avalon readdata
//   amm_readdatavalid in  1        Avalon readdatavalid
//   outstanding      out  $clog2(RSP_DEPTH+1)  reads accepted but not yet returned on readdatavalid
//   idle             out  1        no command held, outstanding==0, response FIFO empty
//   err_unexp        out  1        sticky: readdatavalid seen while outstanding==0
// BEHAVIOUR
//   Reset values: all amm_* outputs 0; rsp_valid 0; outstanding 0; err_unexp 0; idle 1; FIFO emptied.
//   Reset mid-operation drops held commands, in-flight reads and FIFO contents. No response is
//   generated for dropped reads.
//   Command register (1 entry): an accepted command drives amm_* in the next cycle.
//     amm_read/amm_write hold, with address/data/byteenable stable, while amm_waitrequest=1.
//     The transfer completes on the first cycle with amm_read|amm_write and !amm_waitrequest.
//     With no new command, amm_read/amm_write and all data fields return to 0 after completion.
//   cmd_ready = (!held | (held & !amm_waitrequest)) & (cmd_we | credit>0).
//     This gives back-to-back transfers, one per cycle, when waitrequest=0.
//   credit = RSP_DEPTH - outstanding - fifo_count.
//     Read acceptance increments outstanding; amm_readdatavalid decrements it.
//     Accept and return in the same cycle leave outstanding unchanged.
//     The FIFO therefore never overflows. A full FIFO with rsp_ready=0 stalls only reads; writes proceed.
//   Writes are posted and produce no response.
//   Write/read ordering follows Avalon semantics only; no read-after-write hazard logic.
//   readdatavalid pushes amm_readdata into the FIFO.
//     rsp_valid rises the cycle after the push (min read latency: cmd accept -> rsp_valid = 3 cycles
//     with a 0-wait slave that returns data 1 cycle after the command).
//     Simultaneous push and pop are allowed at any fill level, including empty->passthrough next cycle.
//   readdatavalid with outstanding==0: data discarded, err_unexp set until reset.
//   Pointers wrap modulo RSP_DEPTH. Counters never wrap: outstanding is bounded by RSP_DEPTH.
//   idle is combinational from registered state.
// TESTING
//   Write addr 0x0010 data 0xDEADBEEF strb 0xF, waitrequest=0 -> 1-cycle amm_write with exact
//     fields, then amm_* back to 0, idle=1.
//   Write strb 0x3 with waitrequest high 3 cycles -> amm_write held 4 cycles, fields stable,
//     cmd_ready=0 for those 3 stalled cycles.
//   4 back-to-back reads of 0x0,0x4,0x8,0xC; slave returns 0xA0..0xA3 at 2-cycle latency,
//     rsp_ready=1 -> 4 responses in order, outstanding peaks at 2, no bubbles on amm_read.
//   RSP_DEPTH=4, rsp_ready=0, issue 6 reads -> exactly 4 accepted, cmd_ready=0 after that.
//     Set rsp_ready=1 -> remaining 2 reads issue; all 6 data words delivered in order.
//   Pulse readdatavalid with nothing outstanding -> err_unexp=1 and sticky, FIFO unchanged.
//     Then assert reset with 2 reads in flight -> all outputs at reset values next cycle,
//     outstanding=0, err_unexp=0.

Source files
------------

// File: rtl/amm_master_pipe.sv
// amm_master_pipe: Avalon-MM master with a one-entry command register and pipelined reads.
//
// This block turns a valid/ready command stream into Avalon-MM read and write transfers.
// Read data returns in command order through a response FIFO.
// The number of reads in flight plus the number of buffered responses never exceeds
// RSP_DEPTH, so the FIFO cannot overflow.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   cmd_*              command stream: valid/ready, we, addr, wdata, strb
//   rsp_*              read response stream: valid/ready, rdata (in command order)
//   amm_*              Avalon-MM master interface
//   outstanding        reads accepted but not yet returned on readdatavalid
//   idle               no command held, nothing outstanding, response FIFO empty
//   err_unexp          sticky; set by readdatavalid while nothing is outstanding
module amm_master_pipe #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STRB_W    = DATA_W / 8,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_we,
    input  logic [ADDR_W-1:0]                  cmd_addr,
    input  logic [DATA_W-1:0]                  cmd_wdata,
    input  logic [STRB_W-1:0]                  cmd_strb,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_W-1:0]                  rsp_rdata,
    output logic [ADDR_W-1:0]                  amm_address,
    output logic                               amm_read,
    output logic                               amm_write,
    output logic [DATA_W-1:0]                  amm_writedata,
    output logic [STRB_W-1:0]                  amm_byteenable,
    input  logic                               amm_waitrequest,
    input  logic [DATA_W-1:0]                  amm_readdata,
    input  logic                               amm_readdatavalid,
    output logic [$clog2(RSP_DEPTH+1)-1:0]     outstanding,
    output logic                               idle,
    output logic                               err_unexp
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

    // Command register
    logic              held_q, held_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;

    // Read tracking and response FIFO
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic              err_q, err_d;

    logic [CNT_W:0] used;
    logic           has_credit;
    logic           xfer_done;
    logic           cmd_fire;
    logic           rd_accept;
    logic           push;
    logic           pop;

    assign used       = {1'b0, out_q} + {1'b0, cnt_q};
    assign has_credit = (used < DEPTH_C);
    assign xfer_done  = held_q & ~amm_waitrequest;
    // Writes never need credit; only reads reserve a FIFO slot.
    assign cmd_ready  = (~held_q | ~amm_waitrequest) & (cmd_we | has_credit);
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign rd_accept  = cmd_fire & ~cmd_we;
    // Data returned with nothing outstanding is dropped, not buffered.
    assign push       = amm_readdatavalid & (out_q != '0);
    assign pop        = rsp_valid & rsp_ready;

    always_comb begin
        held_d  = held_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        if (cmd_fire) begin
            held_d  = 1'b1;
            we_d    = cmd_we;
            addr_d  = cmd_addr;
            wdata_d = cmd_we ? cmd_wdata : '0;
            strb_d  = cmd_we ? cmd_strb : '1;
        end else if (xfer_done) begin
            held_d  = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            strb_d  = '0;
        end
    end

    always_comb begin
        out_d    = out_q + CNT_W'(rd_accept) - CNT_W'(push);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        err_d    = err_q | (amm_readdatavalid & (out_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            held_q   <= held_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; the pointers and the count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= amm_readdata;
        end
    end

    assign amm_read       = held_q & ~we_q;
    assign amm_write      = held_q & we_q;
    assign amm_address    = addr_q;
    assign amm_writedata  = wdata_q;
    assign amm_byteenable = strb_q;

    assign rsp_valid   = (cnt_q != '0);
    assign rsp_rdata   = mem_q[rd_ptr_q];
    assign outstanding = out_q;
    assign idle        = ~held_q & (out_q == '0) & (cnt_q == '0);
    assign err_unexp   = err_q;

endmodule

// File: tb/tb_amm_master_pipe.sv
// Directed testbench for amm_master_pipe (ADDR_W=16, DATA_W=32, RSP_DEPTH=4).
// The slave model returns 0xA0 + addr/4 in the cycle after a read completes.
module tb_amm_master_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [15:0] amm_address;
    logic        amm_read, amm_write;
    logic [31:0] amm_writedata;
    logic [3:0]  amm_byteenable;
    logic        amm_waitrequest;
    logic [31:0] amm_readdata;
    logic        amm_readdatavalid;
    logic [2:0]  outstanding;
    logic        idle, err_unexp;

    int checks = 0;
    int errors = 0;
    logic [31:0] rx[$];
    int   peak;
    logic slave_en;

    always #5 clk = ~clk;

    amm_master_pipe dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_we           (cmd_we),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .cmd_strb         (cmd_strb),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .amm_address      (amm_address),
        .amm_read         (amm_read),
        .amm_write        (amm_write),
        .amm_writedata    (amm_writedata),
        .amm_byteenable   (amm_byteenable),
        .amm_waitrequest  (amm_waitrequest),
        .amm_readdata     (amm_readdata),
        .amm_readdatavalid(amm_readdatavalid),
        .outstanding      (outstanding),
        .idle             (idle),
        .err_unexp        (err_unexp)
    );

    // Slave: a read completing in cycle N returns its data during cycle N+1.
    initial begin
        logic        fire;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            fire = amm_read && !amm_waitrequest;
            a    = amm_address;
            @(posedge clk);
            #1;
            if (slave_en) begin
                amm_readdatavalid = fire;
                amm_readdata      = fire ? 32'hA0 + 32'(a >> 2) : 32'h0;
            end
        end
    end

    // Response collector and outstanding peak tracker.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) rx.push_back(rsp_rdata);
        if (int'(outstanding) > peak) peak = int'(outstanding);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n);
        for (int c = 0; c < 40 && rx.size() < n; c++) cyc();
        chk("rx_count", 64'(rx.size()), 64'(n));
    endtask

    initial begin
        int   n_acc;
        logic fire;

        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; rsp_ready = 1'b0; amm_waitrequest = 1'b0; amm_readdata = '0;
        amm_readdatavalid = 1'b0; slave_en = 1'b1; peak = 0;
        cyc(); cyc();
        #1;
        chk("rst_read", 64'(amm_read), 64'd0);
        chk("rst_write", 64'(amm_write), 64'd0);
        chk("rst_addr", 64'(amm_address), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err_unexp), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        reset = 1'b0;
        cyc();

        // Single write, no wait states.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0010;
        cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'hF;
        #1;
        chk("w1_ready", 64'(cmd_ready), 64'd1);
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk("w1_write", 64'(amm_write), 64'd1);
        chk("w1_read", 64'(amm_read), 64'd0);
        chk("w1_addr", 64'(amm_address), 64'h0010);
        chk("w1_data", 64'(amm_writedata), 64'hDEADBEEF);
        chk("w1_be", 64'(amm_byteenable), 64'hF);
        chk("w1_busy", 64'(idle), 64'd0);
        cyc();
        #1;
        chk("w1_write_off", 64'(amm_write), 64'd0);
        chk("w1_addr_off", 64'(amm_address), 64'd0);
        chk("w1_data_off", 64'(amm_writedata), 64'd0);
        chk("w1_be_off", 64'(amm_byteenable), 64'd0);
        chk("w1_idle", 64'(idle), 64'd1);

        // Write held by three waitrequest cycles.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0020;
        cmd_wdata = 32'h12345678; cmd_strb = 4'h3;
        cyc();
        cmd_valid = 1'b0; amm_waitrequest = 1'b1; cmd_wdata = 32'hFFFFFFFF; cmd_addr = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("w2_write_held", 64'(amm_write), 64'd1);
            chk("w2_addr_stable", 64'(amm_address), 64'h0020);
            chk("w2_data_stable", 64'(amm_writedata), 64'h12345678);
            chk("w2_be_stable", 64'(amm_byteenable), 64'h3);
            chk("w2_ready_stall", 64'(cmd_ready), 64'd0);
            cyc();
        end
        amm_waitrequest = 1'b0;
        #1;
        chk("w2_write_4th", 64'(amm_write), 64'd1);
        chk("w2_ready_free", 64'(cmd_ready), 64'd1);
        cyc();
        #1;
        chk("w2_write_off", 64'(amm_write), 64'd0);
        chk("w2_idle", 64'(idle), 64'd1);

        // Four back-to-back reads, responses consumed immediately.
        rx.delete(); peak = 0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_strb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            cmd_addr = 16'(4 * i);
            #1;
            chk("r4_ready", 64'(cmd_ready), 64'd1);
            cyc();
            #1;
            chk("r4_read", 64'(amm_read), 64'd1);
            chk("r4_addr", 64'(amm_address), 64'(4 * i));
            chk("r4_be_all", 64'(amm_byteenable), 64'hF);
        end
        cmd_valid = 1'b0;
        wait_rx(4);
        for (int i = 0; i < 4 && i < rx.size(); i++) chk("r4_data", 64'(rx[i]), 64'(32'hA0 + i));
        chk("r4_peak", 64'(peak), 64'd2);
        cyc();
        #1;
        chk("r4_idle", 64'(idle), 64'd1);

        // Six reads with responses blocked: only four may be accepted.
        rx.delete(); rsp_ready = 1'b0; n_acc = 0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0010;
        for (int c = 0; c < 10; c++) begin
            #1;
            fire = cmd_ready && cmd_valid;
            cyc();
            if (fire) begin
                n_acc++;
                cmd_addr = 16'(16 + 4 * n_acc);
                if (n_acc == 6) cmd_valid = 1'b0;
            end
        end
        #1;
        chk("r6_accepted", 64'(n_acc), 64'd4);
        chk("r6_ready_low", 64'(cmd_ready), 64'd0);
        chk("r6_outstanding", 64'(outstanding), 64'd0);
        chk("r6_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("r6_head", 64'(rsp_rdata), 64'hA4);
        // A write still goes through while reads are blocked.
        cmd_we = 1'b1;
        #1;
        chk("r6_write_ok", 64'(cmd_ready), 64'd1);
        cmd_we = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && n_acc < 6; c++) begin
            #1;
            fire = cmd_ready && cmd_valid;
            cyc();
            if (fire) begin
                n_acc++;
                cmd_addr = 16'(16 + 4 * n_acc);
                if (n_acc == 6) cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("r6_all_accepted", 64'(n_acc), 64'd6);
        wait_rx(6);
        for (int i = 0; i < 6 && i < rx.size(); i++) chk("r6_data", 64'(rx[i]), 64'(32'hA4 + i));
        cyc();
        #1;
        chk("r6_idle", 64'(idle), 64'd1);

        // Unexpected readdatavalid.
        slave_en = 1'b0; rx.delete();
        amm_readdatavalid = 1'b1; amm_readdata = 32'h55;
        cyc();
        amm_readdatavalid = 1'b0;
        #1;
        chk("ue_err", 64'(err_unexp), 64'd1);
        chk("ue_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("ue_outstanding", 64'(outstanding), 64'd0);
        cyc(); cyc(); cyc();
        #1;
        chk("ue_sticky", 64'(err_unexp), 64'd1);
        chk("ue_idle", 64'(idle), 64'd1);
        chk("ue_no_rx", 64'(rx.size()), 64'd0);

        // Reset with two reads in flight.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0000;
        cyc();
        cmd_addr = 16'h0004;
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk("rr_outstanding_2", 64'(outstanding), 64'd2);
        reset = 1'b1;
        cyc();
        #1;
        chk("rr_read", 64'(amm_read), 64'd0);
        chk("rr_addr", 64'(amm_address), 64'd0);
        chk("rr_outstanding", 64'(outstanding), 64'd0);
        chk("rr_err", 64'(err_unexp), 64'd0);
        chk("rr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rr_idle", 64'(idle), 64'd1);
        reset = 1'b0;
        cyc(); cyc();
        #1;
        chk("rr_no_rsp", 64'(rsp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
